// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types, constants and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WBACK,
    FIN
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  PC_IDX     = 4'd15;

  // Number of registers named in a 16-bit register list.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Control, register-file and data-memory signals seen by the sequencer.
interface ldm_stm_sequencer_if #(parameter int unsigned W = 32);

  logic         START;
  logic         IS_LOAD;
  logic         UP;
  logic         PRE;
  logic         WB_EN;
  logic [3:0]   BASE_REG;
  logic [W-1:0] BASE_ADDR;
  logic [15:0]  REG_LIST;
  logic [W-1:0] RF_DO;
  logic [W-1:0] MEM_RD;

  logic [3:0]   RF_AD;
  logic [3:0]   RF_WAD;
  logic [W-1:0] RF_WDI;
  logic         RF_WE;
  logic         PC_WE;
  logic [W-1:0] PC_WD;
  logic [W-1:0] MEM_ADDR;
  logic         MEM_WE;
  logic [W-1:0] MEM_WD;
  logic         BUSY;
  logic         DONE;

  // Decode unit, register file and memory side.
  modport master (
    output START, IS_LOAD, UP, PRE, WB_EN, BASE_REG, BASE_ADDR, REG_LIST,
           RF_DO, MEM_RD,
    input  RF_AD, RF_WAD, RF_WDI, RF_WE, PC_WE, PC_WD,
           MEM_ADDR, MEM_WE, MEM_WD, BUSY, DONE
  );

  // Sequencer side.
  modport slave (
    input  START, IS_LOAD, UP, PRE, WB_EN, BASE_REG, BASE_ADDR, REG_LIST,
           RF_DO, MEM_RD,
    output RF_AD, RF_WAD, RF_WDI, RF_WE, PC_WE, PC_WD,
           MEM_ADDR, MEM_WE, MEM_WD, BUSY, DONE
  );

endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit16.sv
// Combinational 16-to-4 priority encoder: index of the lowest set bit.
module lowest_set_bit16 (
  input  logic [15:0] bits,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan upward, keeping the first set bit found.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (bits[i] && !valid) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list lowest index first, one transfer
// per cycle, then optionally writes the final address back to the base.
import ldm_stm_sequencer_pkg::*;

module ldm_stm_sequencer #(
  parameter int unsigned W = 32
) (
  input logic               CLK,
  input logic               RESET,
  ldm_stm_sequencer_if.slave bus
);

  state_t       state, state_nx;
  logic [15:0]  rem_list;
  logic         is_load_q;
  logic         wb_ok_q;
  logic [3:0]   base_reg_q;
  logic [W-1:0] cur_addr;
  logic [W-1:0] final_addr;

  logic [4:0]   n_cnt;
  logic [W-1:0] span;
  logic [W-1:0] start_addr;
  logic [W-1:0] end_addr;
  logic         wb_ok;
  logic [15:0]  rem_next;
  logic [3:0]   idx;
  logic         idx_valid;

  lowest_set_bit16 u_lsb (
    .bits  (rem_list),
    .idx   (idx),
    .valid (idx_valid)
  );

  // rem & (rem-1) drops the lowest set bit, i.e. the register just transferred.
  assign rem_next = rem_list & (rem_list - 16'd1);

  // Transfer geometry derived from the inputs presented with START.
  always_comb begin
    n_cnt    = popcount16(bus.REG_LIST);
    span     = W'(n_cnt) * W'(WORD_BYTES);
    end_addr = bus.UP ? bus.BASE_ADDR + span : bus.BASE_ADDR - span;
    if (bus.UP) begin
      start_addr = bus.PRE ? bus.BASE_ADDR + W'(WORD_BYTES) : bus.BASE_ADDR;
    end else begin
      start_addr = bus.PRE ? bus.BASE_ADDR - span
                           : bus.BASE_ADDR - span + W'(WORD_BYTES);
    end
    wb_ok = bus.WB_EN && !(bus.IS_LOAD && bus.REG_LIST[bus.BASE_REG])
            && (bus.BASE_REG != PC_IDX);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Operation capture on accepted START and per-transfer list/address advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rem_list   <= '0;
      is_load_q  <= 1'b0;
      wb_ok_q    <= 1'b0;
      base_reg_q <= '0;
      cur_addr   <= '0;
      final_addr <= '0;
    end else if (state == IDLE && bus.START) begin
      rem_list   <= bus.REG_LIST;
      is_load_q  <= bus.IS_LOAD;
      wb_ok_q    <= wb_ok;
      base_reg_q <= bus.BASE_REG;
      cur_addr   <= start_addr;
      final_addr <= end_addr;
    end else if (state == XFER) begin
      rem_list   <= rem_next;
      cur_addr   <= cur_addr + W'(WORD_BYTES);
    end
  end

  // Next-state and Moore strobes; everything idles at zero outside its state.
  always_comb begin
    state_nx     = state;
    bus.RF_AD    = '0;
    bus.RF_WAD   = '0;
    bus.RF_WDI   = '0;
    bus.RF_WE    = 1'b0;
    bus.PC_WE    = 1'b0;
    bus.PC_WD    = '0;
    bus.MEM_ADDR = '0;
    bus.MEM_WE   = 1'b0;
    bus.MEM_WD   = '0;
    bus.BUSY     = 1'b0;
    bus.DONE     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) state_nx = (n_cnt == 5'd0) ? FIN : XFER;
      end
      XFER: begin
        bus.BUSY     = 1'b1;
        bus.MEM_ADDR = cur_addr;
        if (idx_valid) begin
          if (!is_load_q) begin
            bus.RF_AD  = idx;
            bus.MEM_WD = bus.RF_DO;
            bus.MEM_WE = 1'b1;
          end else if (idx == PC_IDX) begin
            bus.PC_WD  = bus.MEM_RD;
            bus.PC_WE  = 1'b1;
          end else begin
            bus.RF_WAD = idx;
            bus.RF_WDI = bus.MEM_RD;
            bus.RF_WE  = 1'b1;
          end
        end
        if (!idx_valid || rem_next == 16'd0) state_nx = wb_ok_q ? WBACK : FIN;
      end
      WBACK: begin
        bus.BUSY   = 1'b1;
        bus.RF_WAD = base_reg_q;
        bus.RF_WDI = final_addr;
        bus.RF_WE  = 1'b1;
        state_nx   = FIN;
      end
      FIN: begin
        bus.DONE = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: the bench plays register file,
// PC and data memory, and predicts every cycle from the block-transfer rules.
module tb_ldm_stm_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldm_stm_sequencer_if #(.W(32)) bus ();

  ldm_stm_sequencer #(.W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  logic [31:0] rf  [0:15];
  logic [31:0] mem [0:1023];
  logic [31:0] pc_val;

  int checks = 0;
  int errors = 0;

  assign bus.RF_DO  = (bus.RF_AD == 4'd15) ? pc_val + 32'd8 : rf[bus.RF_AD];
  assign bus.MEM_RD = mem[bus.MEM_ADDR[11:2]];

  // Register file, PC and memory respond to the sequencer's write strobes.
  always @(posedge clk) begin
    if (bus.RF_WE)  rf[bus.RF_WAD] = bus.RF_WDI;
    if (bus.MEM_WE) mem[bus.MEM_ADDR[11:2]] = bus.MEM_WD;
    if (bus.PC_WE)  pc_val = bus.PC_WD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.START     = 1'($urandom_range(0, 1));
    bus.IS_LOAD   = 1'($urandom_range(0, 1));
    bus.UP        = 1'($urandom_range(0, 1));
    bus.PRE       = 1'($urandom_range(0, 1));
    bus.WB_EN     = 1'($urandom_range(0, 1));
    bus.BASE_REG  = 4'($urandom);
    bus.BASE_ADDR = $urandom;
    bus.REG_LIST  = 16'($urandom);
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_done"},  32'(bus.DONE),   32'd0);
    check({tag, "_busy"},  32'(bus.BUSY),   32'd0);
    check({tag, "_memwe"}, 32'(bus.MEM_WE), 32'd0);
    check({tag, "_rfwe"},  32'(bus.RF_WE),  32'd0);
    check({tag, "_pcwe"},  32'(bus.PC_WE),  32'd0);
  endtask

  // One complete LDM/STM, predicted from the list, mode and base alone.
  task automatic run_op(input bit ld, input bit up, input bit pre, input bit wb_en,
                        input logic [3:0] br, input logic [31:0] base,
                        input logic [15:0] list);
    int          idxs[$];
    int          n;
    int          last;
    int          mism;
    bit          wb;
    logic [31:0] start, fin_addr, addr, exp_pc;
    logic [31:0] exp_val [16];
    logic [31:0] exp_rf  [16];

    for (int i = 0; i < 16; i++) if (list[i]) idxs.push_back(i);
    n        = idxs.size();
    fin_addr = up ? base + 32'(n) * 4 : base - 32'(n) * 4;
    if (up) start = pre ? base + 4 : base;
    else    start = pre ? base - 32'(n) * 4 : base - 32'(n) * 4 + 4;
    wb = wb_en && !(ld && list[br]) && (br != 4'd15) && (n > 0);

    for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];
    exp_pc = pc_val;
    for (int k = 0; k < n; k++) begin
      addr = start + 32'(k) * 4;
      if (ld) exp_val[k] = mem[addr[11:2]];
      else    exp_val[k] = (idxs[k] == 15) ? pc_val + 8 : rf[idxs[k]];
      if (ld && idxs[k] != 15) exp_rf[idxs[k]] = exp_val[k];
      if (ld && idxs[k] == 15) exp_pc = exp_val[k];
    end
    if (wb) exp_rf[br] = fin_addr;

    bus.START = 1'b1; bus.IS_LOAD = ld; bus.UP = up; bus.PRE = pre;
    bus.WB_EN = wb_en; bus.BASE_REG = br; bus.BASE_ADDR = base; bus.REG_LIST = list;
    @(posedge clk); #1;

    last = n + (wb ? 1 : 0) + 1;
    for (int c = 1; c <= last; c++) begin
      if (c <= n) begin
        addr = start + 32'(c - 1) * 4;
        check("xfer_busy", 32'(bus.BUSY), 32'd1);
        check("xfer_done", 32'(bus.DONE), 32'd0);
        check("xfer_addr", bus.MEM_ADDR, addr);
        check("xfer_memwe", 32'(bus.MEM_WE), ld ? 32'd0 : 32'd1);
        if (!ld) begin
          check("stm_rfad", 32'(bus.RF_AD), 32'(idxs[c - 1]));
          check("stm_wd", bus.MEM_WD, exp_val[c - 1]);
          check("stm_rfwe", 32'(bus.RF_WE), 32'd0);
          check("stm_pcwe", 32'(bus.PC_WE), 32'd0);
        end else if (idxs[c - 1] == 15) begin
          check("ldm_pc_rfwe", 32'(bus.RF_WE), 32'd0);
          check("ldm_pc_pcwe", 32'(bus.PC_WE), 32'd1);
          check("ldm_pc_wd", bus.PC_WD, exp_val[c - 1]);
        end else begin
          check("ldm_rfwe", 32'(bus.RF_WE), 32'd1);
          check("ldm_pcwe", 32'(bus.PC_WE), 32'd0);
          check("ldm_wad", 32'(bus.RF_WAD), 32'(idxs[c - 1]));
          check("ldm_wdi", bus.RF_WDI, exp_val[c - 1]);
        end
      end else if (wb && c == n + 1) begin
        check("wb_busy", 32'(bus.BUSY), 32'd1);
        check("wb_done", 32'(bus.DONE), 32'd0);
        check("wb_rfwe", 32'(bus.RF_WE), 32'd1);
        check("wb_wad", 32'(bus.RF_WAD), 32'(br));
        check("wb_wdi", bus.RF_WDI, fin_addr);
        check("wb_memwe", 32'(bus.MEM_WE), 32'd0);
      end else begin
        check("fin_done", 32'(bus.DONE), 32'd1);
        check("fin_busy", 32'(bus.BUSY), 32'd0);
        check("fin_enables", {29'd0, bus.RF_WE, bus.MEM_WE, bus.PC_WE}, 32'd0);
      end
      if (c == last) bus.START = 1'b0;
      else           scramble_inputs();
      @(posedge clk); #1;
    end
    idle_checks("after");

    mism = 0;
    for (int i = 0; i < 15; i++) if (rf[i] !== exp_rf[i]) mism++;
    check("rf_final_mismatches", 32'(mism), 32'd0);
    check("pc_final", pc_val, exp_pc);
    if (!ld) begin
      mism = 0;
      for (int k = 0; k < n; k++) begin
        addr = start + 32'(k) * 4;
        if (mem[addr[11:2]] !== exp_val[k]) mism++;
      end
      check("mem_final_mismatches", 32'(mism), 32'd0);
    end
  endtask

  // Reset raised during the second transfer of a four-register STM.
  task automatic run_reset_abort();
    bus.START = 1'b1; bus.IS_LOAD = 1'b0; bus.UP = 1'b1; bus.PRE = 1'b0;
    bus.WB_EN = 1'b1; bus.BASE_REG = 4'd13; bus.BASE_ADDR = 32'h500;
    bus.REG_LIST = 16'h000F;
    @(posedge clk); #1;
    bus.START = 1'b0;
    check("rst_c1_memwe", 32'(bus.MEM_WE), 32'd1);
    @(posedge clk); #1;
    check("rst_c2_memwe", 32'(bus.MEM_WE), 32'd1);
    check("rst_c2_addr", bus.MEM_ADDR, 32'h504);
    rst = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      @(posedge clk); #1;
      idle_checks("rst_abort");
    end
    rst = 1'b0;
    @(posedge clk); #1;
    idle_checks("rst_release");
  endtask

  initial begin
    logic [15:0] rl;
    rst = 1'b1;
    bus.START = 1'b0; bus.IS_LOAD = 1'b0; bus.UP = 1'b0; bus.PRE = 1'b0;
    bus.WB_EN = 1'b0; bus.BASE_REG = '0; bus.BASE_ADDR = '0; bus.REG_LIST = '0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    pc_val = 32'h0000_8000;

    repeat (2) @(posedge clk);
    #1;
    idle_checks("reset");
    check("reset_addr", bus.MEM_ADDR, 32'd0);
    check("reset_wdi", bus.RF_WDI, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // STM IA, R1-R3, writeback to R13.
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'h000E);
    check("stm_ia_r13", rf[13], 32'h10C);
    // LDM DB, R0, R1 and PC, no writeback.
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 32'h200, 16'h8003);
    // LDM IA with the base in the list: loaded value wins.
    mem[32'h40 >> 2] = 32'hA;
    mem[32'h44 >> 2] = 32'hB;
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h40, 16'h0011);
    check("ldm_base_loaded_r4", rf[4], 32'hB);
    // Empty list: straight to completion.
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h80, 16'h0000);
    // STM DA, R4-R7, writeback to R2.
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h300, 16'h00F0);
    check("stm_da_r2", rf[2], 32'h2F0);
    // STM of the PC stores PC+8.
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h600, 16'h8000);

    run_reset_abort();

    for (int t = 0; t < 40; t++) begin
      rl = 16'($urandom);
      if (t % 3 == 0) rl = rl & 16'($urandom);
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom), $urandom & 32'hFFFF_FFFC, rl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle block-transfer engine for LDM/STM. It drives the register file from the initiator side: read address for stores, write address/data/enable for loads and base writeback. It walks a 16-bit register list lowest-index first, transferring one register per cycle against a combinational-read data memory. It sits between the decode/control unit and the register file / data memory.

Parameters:
W, 32, datapath and address width in bits

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, synchronous, active-high
START  in  1  begin transfer; sampled only in IDLE
IS_LOAD  in  1  1 = LDM, 0 = STM
UP  in  1  1 = increment, 0 = decrement
PRE  in  1  1 = pre-index (IB/DB), 0 = post-index (IA/DA)
WB_EN  in  1  write final address back to base register
BASE_REG  in  4  base register number
BASE_ADDR  in  W  base register value, sampled with START
REG_LIST  in  16  register list, bit i = Ri
RF_DO  in  W  register-file read data for RF_AD (R15 source = PC+8)
MEM_RD  in  W  data-memory read data, combinational from MEM_ADDR
RF_AD  out  4  register-file read address
RF_WAD  out  4  register-file write address
RF_WDI  out  W  register-file write data
RF_WE  out  1  register-file write enable (never asserted for R15)
PC_WE  out  1  PC load strobe for LDM of R15
PC_WD  out  W  PC load value
MEM_ADDR  out  W  byte address, word aligned
MEM_WE  out  1  data-memory write enable
MEM_WD  out  W  data-memory write data
BUSY  out  1  high from the cycle after accepted START until DONE
DONE  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, XFER, WBACK, FIN. Reset: state IDLE, all enables/BUSY/DONE 0, address/data outputs 0.
- IDLE + START: latch REG_LIST into rem_list, n = popcount(REG_LIST), mode, BASE_REG.
- Start address: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n. Final address: base+4n if UP, else base-4n. Arithmetic is modulo 2^W.
- Next state from IDLE+START: XFER if n>0; FIN if n=0. An empty list performs no transfers and no writeback.
- XFER, one register per cycle. idx = lowest set bit of rem_list. MEM_ADDR = cur_addr.
  - STM: RF_AD = idx, MEM_WD = RF_DO, MEM_WE = 1.
  - LDM, idx != 15: RF_WAD = idx, RF_WDI = MEM_RD, RF_WE = 1.
  - LDM, idx = 15: PC_WD = MEM_RD, PC_WE = 1, RF_WE = 0.
  - On the clock edge: clear bit idx and add 4 to cur_addr. If rem_list becomes 0: go to WBACK if wb_ok, else FIN.
- wb_ok = WB_EN && !(IS_LOAD && REG_LIST[BASE_REG]) && BASE_REG != 15. For a loaded base, the loaded value wins.
- WBACK (1 cycle): RF_WAD = BASE_REG, RF_WDI = final address, RF_WE = 1. Next state FIN.
- FIN: DONE = 1 for one cycle, then IDLE.
- Strobes, addresses and data are Moore/combinational from state plus latched registers. Outside their state, enables are 0.
- Latency: transfer k (k = 0..n-1) occurs in cycle k+1 after START. DONE is at cycle n+1, or n+2 with writeback.
- START outside IDLE is ignored. Inputs other than RF_DO/MEM_RD are ignored after capture.
- RESET mid-operation: IDLE on the next edge, no further RF/MEM/PC writes, no DONE.

Decomposition:
- Shared package: state encoding, WORD_BYTES = 4, PC_IDX = 15.
- Sub-module lowest_set_bit16: combinational 16-to-4 priority encoder with a valid flag.
- popcount: a function in the package.

Test Plan:
- STM IA, list 0x000E, base 0x100, BASE_REG 13, WB_EN:
  - Cycles 1-3: MEM_WE with addr 0x100/0x104/0x108, RF_AD 1/2/3.
  - Cycle 4: R13 <= 0x10C.
  - Cycle 5: DONE.
- LDM DB, list 0x8003, base 0x200, no WB:
  - R0 <- mem[0x1F4], R1 <- mem[0x1F8].
  - PC_WE with mem[0x1FC]; RF_WE stays 0 in that cycle.
  - DONE at cycle 4.
- LDM IA, list 0x0011, BASE_REG 4, WB_EN, mem[0x40] = 0xA, mem[0x44] = 0xB, base 0x40:
  - R4 = 0xB after the transfers.
  - No WBACK cycle.
  - DONE at cycle 3.
- Empty list with START: no enables asserted, DONE at cycle 1, BUSY low throughout.
- STM DA, list 0x00F0, base 0x300, WB_EN, BASE_REG 2:
  - Addresses 0x2F4, 0x2F8, 0x2FC, 0x300.
  - R2 <= 0x2F0.
  - A second START pulsed mid-transfer is ignored.
- RESET asserted in cycle 2 of a 4-register STM: no MEM_WE from cycle 3 onward, no DONE, IDLE.
